// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer sample sequencer.
package accel_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        CFG_REQ  = 3'd0,
        CFG_WAIT = 3'd1,
        IDLE     = 3'd2,
        RD_REQ   = 3'd3,
        RD_WAIT  = 3'd4,
        PUBLISH  = 3'd5
    } state_t;

    // Accelerometer register map.
    localparam logic [5:0] CTRL_REG1 = 6'h20;
    localparam logic [5:0] OUT_X_L   = 6'h28;

    // Default configuration: output data rate on, X/Y/Z axes enabled.
    localparam logic [7:0] CFG_DEFAULT = 8'h27;

    localparam int SAMPLE_DIV_DEFAULT  = 12000;
    localparam int TIMEOUT_CYC_DEFAULT = 255;

    // Number of output bytes read per burst (XL,XH,YL,YH,ZL,ZH).
    localparam int NUM_BYTES = 6;

endpackage

// File: rtl/accel_sample_sequencer_if.sv
// Bus between the sample sequencer (master) and the SPI single-byte engine (slave).
//
// Handshake: the master raises spi_req together with stable spi_rw/spi_addr/spi_wdata
// and holds all four until the slave pulses spi_done for exactly one cycle; spi_rdata
// is valid only in that spi_done cycle. The master drops spi_req the cycle after
// spi_done and keeps it low for at least one cycle before the next request.
// A spi_done while no request is outstanding carries no meaning.
interface accel_sample_sequencer_if;
    logic       spi_req;
    logic       spi_rw;
    logic [5:0] spi_addr;
    logic [7:0] spi_wdata;
    logic       spi_done;
    logic [7:0] spi_rdata;

    modport master (
        output spi_req, spi_rw, spi_addr, spi_wdata,
        input  spi_done, spi_rdata
    );

    modport slave (
        input  spi_req, spi_rw, spi_addr, spi_wdata,
        output spi_done, spi_rdata
    );
endinterface

// File: rtl/accel_tick_gen.sv
// Free-running sample-period counter; emits a one-cycle tick every DIV cycles while run=1.
module accel_tick_gen #(
    parameter int DIV = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Count 0..DIV-1 and wrap; held at zero until the sequencer is configured.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = run && (count == LAST);
endmodule

// File: rtl/accel_sample_sequencer.sv
// Accelerometer sample sequencer: one configuration write after reset, then periodic
// six-byte output-register bursts assembled into signed X/Y/Z samples.
module accel_sample_sequencer
    import accel_pkg::*;
#(
    parameter int         SAMPLE_DIV  = SAMPLE_DIV_DEFAULT,
    parameter logic [5:0] CFG_ADDR    = CTRL_REG1,
    parameter logic [7:0] CFG_DATA    = CFG_DEFAULT,
    parameter logic [5:0] OUT_BASE    = OUT_X_L,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                      CLK12M,
    input  logic                      RST,
    input  logic                      enable,
    accel_sample_sequencer_if.master  spi,
    output logic signed [15:0]        accel_x,
    output logic signed [15:0]        accel_y,
    output logic signed [15:0]        accel_z,
    output logic                      sample_valid,
    output logic                      init_done,
    output logic                      timeout_err,
    output state_t                    state_dbg
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);
    localparam logic [2:0]    LAST_IDX  = 3'(NUM_BYTES - 1);

    state_t        state;
    logic [2:0]    idx;
    logic [TW-1:0] tcnt;
    logic [7:0]    shadow [NUM_BYTES];
    logic          tick;
    logic          timeout;

    // The sample timer only starts once the sensor has been configured.
    accel_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
        .clk  (CLK12M),
        .rst  (RST),
        .run  (init_done),
        .tick (tick)
    );

    // spi_done is checked before timeout in the wait states, so a same-cycle done wins.
    assign timeout   = (tcnt == TMO_LIMIT);
    assign state_dbg = state;

    // Sequencer FSM with registered bus outputs, shadow bytes and published samples.
    always_ff @(posedge CLK12M) begin
        if (RST) begin
            state         <= CFG_REQ;
            idx           <= '0;
            tcnt          <= '0;
            spi.spi_req   <= 1'b0;
            spi.spi_rw    <= 1'b0;
            spi.spi_addr  <= '0;
            spi.spi_wdata <= '0;
            accel_x       <= '0;
            accel_y       <= '0;
            accel_z       <= '0;
            sample_valid  <= 1'b0;
            init_done     <= 1'b0;
            timeout_err   <= 1'b0;
            for (int i = 0; i < NUM_BYTES; i++) shadow[i] <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                CFG_REQ: begin
                    spi.spi_req   <= 1'b1;
                    spi.spi_rw    <= 1'b0;
                    spi.spi_addr  <= CFG_ADDR;
                    spi.spi_wdata <= CFG_DATA;
                    tcnt          <= '0;
                    state         <= CFG_WAIT;
                end
                CFG_WAIT: begin
                    if (spi.spi_done) begin
                        init_done   <= 1'b1;
                        spi.spi_req <= 1'b0;
                        state       <= IDLE;
                    end else if (timeout) begin
                        timeout_err <= 1'b1;
                        spi.spi_req <= 1'b0;
                        state       <= CFG_REQ;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                IDLE: begin
                    // Ticks arriving outside IDLE are simply lost: no catch-up burst.
                    if (tick && enable) state <= RD_REQ;
                end
                RD_REQ: begin
                    spi.spi_req   <= 1'b1;
                    spi.spi_rw    <= 1'b1;
                    spi.spi_addr  <= OUT_BASE + {3'b000, idx};
                    spi.spi_wdata <= '0;
                    tcnt          <= '0;
                    state         <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (spi.spi_done) begin
                        shadow[idx] <= spi.spi_rdata;
                        spi.spi_req <= 1'b0;
                        if (idx == LAST_IDX) begin
                            // The sixth byte bypasses the shadow so the whole sample
                            // is presented, with its strobe, during the PUBLISH cycle.
                            idx          <= '0;
                            accel_x      <= {shadow[1], shadow[0]};
                            accel_y      <= {shadow[3], shadow[2]};
                            accel_z      <= {spi.spi_rdata, shadow[4]};
                            sample_valid <= 1'b1;
                            state        <= PUBLISH;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= RD_REQ;
                        end
                    end else if (timeout) begin
                        // Abandon the burst; the shadow bytes are never published.
                        timeout_err <= 1'b1;
                        idx         <= '0;
                        spi.spi_req <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                PUBLISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= CFG_REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_accel_sample_sequencer.sv
// Directed bench for accel_sample_sequencer with a behavioural SPI engine model.
module tb_accel_sample_sequencer;
    import accel_pkg::*;

    localparam int DIV = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] accel_x, accel_y, accel_z;
    logic        sample_valid, init_done, timeout_err;
    state_t      state_dbg;

    accel_sample_sequencer_if bus ();

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Engine model controls.
    int base_lat    = 34;
    int special_txn = -1;
    int special_lat = 0;
    int drop_txn    = -1;

    logic [7:0] data_q[$];
    logic [5:0] txn_addr[$];
    logic       txn_rw[$];
    logic [7:0] txn_wdata[$];
    int         txn_cyc[$];
    int         done_cyc  = 0;
    int         valid_cnt = 0;

    accel_sample_sequencer #(.SAMPLE_DIV(DIV)) dut (
        .CLK12M       (clk),
        .RST          (rst),
        .enable       (enable),
        .spi          (bus),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .sample_valid (sample_valid),
        .init_done    (init_done),
        .timeout_err  (timeout_err),
        .state_dbg    (state_dbg)
    );

    // Clock and cycle counter.
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic bit cond(input int what, input int arg);
        case (what)
            0:       return sample_valid === 1'b1;
            1:       return init_done === 1'b1;
            2:       return timeout_err === 1'b1;
            default: return txn_addr.size() >= arg;
        endcase
    endfunction

    task automatic wait_until(input int what, input int arg, input int limit, input string tag);
        int n;
        n = 0;
        while (!cond(what, arg) && n < limit) begin
            step();
            n++;
        end
        check(tag, 32'(cond(what, arg)), 32'd1);
    endtask

    // SPI engine model: logs each request, acks after a latency, one-cycle spi_done.
    initial begin : engine
        int cnt;
        int cur;
        int lat;
        bit active;
        bit acked;
        bit ack_prev;
        cnt = 0; cur = 0; lat = 0; active = 0; acked = 0; ack_prev = 0;
        bus.spi_done  = 1'b0;
        bus.spi_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.spi_done = 1'b0;
            if (ack_prev && !rst) check("req_falls_after_done", 32'(bus.spi_req), 32'd0);
            ack_prev = 0;
            if (rst) begin
                active = 0; acked = 0; cnt = 0;
            end else if (bus.spi_req) begin
                if (!active) begin
                    active = 1; acked = 0; cnt = 0;
                    txn_rw.push_back(bus.spi_rw);
                    txn_addr.push_back(bus.spi_addr);
                    txn_wdata.push_back(bus.spi_wdata);
                    txn_cyc.push_back(cyc);
                    cur = txn_addr.size() - 1;
                end
                lat = (cur == special_txn) ? special_lat : base_lat;
                if (!acked && cur != drop_txn && cnt == lat) begin
                    check("addr_stable", 32'(bus.spi_addr), 32'(txn_addr[cur]));
                    bus.spi_done  = 1'b1;
                    bus.spi_rdata = 8'h00;
                    if (bus.spi_rw && data_q.size() > 0) bus.spi_rdata = data_q.pop_front();
                    acked = 1; ack_prev = 1; done_cyc = cyc;
                end
                cnt++;
            end else begin
                active = 0;
            end
        end
    end

    // Count sample_valid cycles.
    initial forever begin
        @(negedge clk);
        if (sample_valid === 1'b1) valid_cnt++;
    end

    initial begin : main
        int t_init;
        int t_tmo;
        int vc;
        int n;

        // Reset state.
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) step();
        check("rst_req", 32'(bus.spi_req), 32'd0);
        check("rst_x", 32'(accel_x), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_init", 32'(init_done), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(CFG_REQ));
        rst = 1'b0;

        // Configuration write, then first burst exactly one period after init_done.
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF0};
        wait_until(1, 0, 200, "init_done_seen");
        t_init = cyc;
        check("cfg_count", 32'(txn_addr.size()), 32'd1);
        check("cfg_rw", 32'(txn_rw[0]), 32'd0);
        check("cfg_addr", 32'(txn_addr[0]), 32'h20);
        check("cfg_wdata", 32'(txn_wdata[0]), 32'h27);
        step();
        check("idle_state", 32'(state_dbg), 32'(IDLE));
        wait_until(0, 0, DIV + 400, "b1_valid_seen");
        check("b1_x", 32'(accel_x), 32'h0201);
        check("b1_y", 32'(accel_y), 32'h0403);
        check("b1_z", 32'(accel_z), 32'hF005);
        check("b1_latency", 32'(cyc - done_cyc), 32'd1);
        check("b1_first_read_delay", 32'(txn_cyc[1] - t_init), 32'(DIV + 1));
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b1_addr%0d", i), 32'(txn_addr[1 + i]), 32'(6'h28 + i));
            check($sformatf("b1_rw%0d", i), 32'(txn_rw[1 + i]), 32'd1);
        end
        step();
        check("b1_valid_width", 32'(sample_valid), 32'd0);

        // Second burst: first byte acked in the very cycle the timeout would fire.
        special_txn = 7;
        special_lat = 255;
        data_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        wait_until(0, 0, DIV + 600, "b2_valid_seen");
        check("b2_x", 32'(accel_x), 32'h1110);
        check("b2_y", 32'(accel_y), 32'h1312);
        check("b2_z", 32'(accel_z), 32'h1514);
        check("b2_no_timeout", 32'(timeout_err), 32'd0);
        check("b2_txn_count", 32'(txn_addr.size()), 32'd13);
        check("b2_period", 32'(txn_cyc[7] - txn_cyc[1]), 32'(DIV));
        vc = valid_cnt;

        // Third burst: third read never acknowledged.
        drop_txn = 15;
        data_q = '{8'h55, 8'h66};
        wait_until(2, 0, DIV + 800, "b3_timeout_seen");
        t_tmo = cyc;
        check("b3_timeout_delay", 32'(t_tmo - txn_cyc[15]), 32'd256);
        check("b3_req_dropped", 32'(bus.spi_req), 32'd0);
        repeat (20) step();
        check("b3_txn_count", 32'(txn_addr.size()), 32'd16);
        check("b3_no_publish", 32'(valid_cnt), 32'(vc));

        // Fourth burst recovers cleanly.
        data_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        wait_until(0, 0, DIV + 400, "b4_valid_seen");
        check("b4_x", 32'(accel_x), 32'h2221);
        check("b4_y", 32'(accel_y), 32'h2423);
        check("b4_z", 32'(accel_z), 32'h2625);
        check("b4_first_addr", 32'(txn_addr[16]), 32'h28);
        check("b4_period", 32'(txn_cyc[16] - txn_cyc[13]), 32'(DIV));
        check("b4_tmo_sticky", 32'(timeout_err), 32'd1);

        // Fifth burst: enable dropped during the second byte.
        data_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        wait_until(3, 24, DIV + 400, "b5_byte2_seen");
        enable = 1'b0;
        wait_until(0, 0, 400, "b5_valid_seen");
        check("b5_x", 32'(accel_x), 32'h3231);
        check("b5_y", 32'(accel_y), 32'h3433);
        check("b5_z", 32'(accel_z), 32'h3635);
        vc = valid_cnt;
        n = txn_addr.size();
        check("b5_txn_count", 32'(n), 32'd28);
        repeat (DIV + 50) step();
        check("disabled_no_req", 32'(txn_addr.size()), 32'(n));
        check("disabled_no_valid", 32'(valid_cnt), 32'(vc));
        check("disabled_req_low", 32'(bus.spi_req), 32'd0);

        // Sixth burst: reset while the fourth byte is outstanding.
        enable = 1'b1;
        data_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        wait_until(3, 32, 2 * DIV + 100, "b6_byte4_seen");
        rst = 1'b1;
        step();
        check("mid_rst_req", 32'(bus.spi_req), 32'd0);
        check("mid_rst_x", 32'(accel_x), 32'd0);
        check("mid_rst_y", 32'(accel_y), 32'd0);
        check("mid_rst_z", 32'(accel_z), 32'd0);
        check("mid_rst_init", 32'(init_done), 32'd0);
        check("mid_rst_tmo", 32'(timeout_err), 32'd0);
        vc = valid_cnt;
        rst = 1'b0;
        data_q.delete();
        data_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
        wait_until(1, 0, 200, "reinit_seen");
        check("recfg_count", 32'(txn_addr.size()), 32'd33);
        check("recfg_rw", 32'(txn_rw[32]), 32'd0);
        check("recfg_addr", 32'(txn_addr[32]), 32'h20);
        check("recfg_wdata", 32'(txn_wdata[32]), 32'h27);
        check("no_stale_publish", 32'(valid_cnt), 32'(vc));
        wait_until(0, 0, DIV + 400, "b7_valid_seen");
        check("b7_x", 32'(accel_x), 32'h5251);
        check("b7_y", 32'(accel_y), 32'h5453);
        check("b7_z", 32'(accel_z), 32'h5655);
        check("b7_first_addr", 32'(txn_addr[33]), 32'h28);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
